// File: rtl/arf_pkg.sv
// arf_pkg: FunSel encodings shared by the address register file and its registers
package arf_pkg;
   typedef enum logic [2:0] {
      FS_DEC      = 3'b000,
      FS_INC      = 3'b001,
      FS_LOAD     = 3'b010,
      FS_CLEAR    = 3'b011,
      FS_LOAD_LO  = 3'b100,
      FS_LOAD_HI  = 3'b101,
      FS_HOLD     = 3'b110,
      FS_HOLD_ALT = 3'b111
   } fun_sel_t;
endpackage

// File: rtl/arf_reg.sv
// arf_reg: one address register with async active-low reset, enable and FunSel decode
module arf_reg
   import arf_pkg::*;
#(
   parameter int              DATA_W  = 16,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  fun_sel_t          fun_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);
   localparam int LO = DATA_W / 2;
   localparam int HI = DATA_W - LO;

   logic [DATA_W-1:0] q_q, q_d;

   always_comb begin
      q_d = fun_i == FS_DEC     ? q_q - 1'b1 :
            fun_i == FS_INC     ? q_q + 1'b1 :
            fun_i == FS_LOAD    ? d_i :
            fun_i == FS_CLEAR   ? '0 :
            fun_i == FS_LOAD_LO ? {{HI{1'b0}}, d_i[LO-1:0]} :
            fun_i == FS_LOAD_HI ? {d_i[HI-1:0], q_q[LO-1:0]} :
                                  q_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) q_q <= RST_VAL;
      else if (en_i) q_q <= q_d;
   end

   assign q_o = q_q;
endmodule

// File: rtl/addr_reg_file_p.sv
// addr_reg_file_p: multi-port address register file with a stack-pointer register.
// Define ARF_BOUNDS_CHECK_EN to enable SP bounds checking with sticky SpOvf/SpUnf.
module addr_reg_file_p
   import arf_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                NUM_REGS = 4,
   parameter int                NUM_RD   = 2,
   parameter int                SP_IDX   = 3,
   parameter logic [DATA_W-1:0] SP_MIN   = '0,
   parameter logic [DATA_W-1:0] SP_MAX   = '1
) (
   input  logic                                 Clock,
   input  logic                                 Reset_n,
   input  logic [DATA_W-1:0]                    I,
   input  logic [2:0]                           FunSel,
   input  logic [NUM_REGS-1:0]                  RegSel,
   input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]   OutSel,
   output logic [NUM_RD*DATA_W-1:0]             Out,
   input  logic                                 FlagClr,
   output logic                                 SpOvf,
   output logic                                 SpUnf
);
   localparam int IDX_W = $clog2(NUM_REGS);

   if (NUM_REGS < 2 || SP_IDX >= NUM_REGS || SP_MIN >= SP_MAX) begin : g_bad_cfg
      $error("addr_reg_file_p: invalid register count, SP index or SP bounds");
   end

   fun_sel_t          fs;
   logic              sp_blk;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] tab  [2**IDX_W];

   assign fs = fun_sel_t'(FunSel);

`ifdef ARF_BOUNDS_CHECK_EN
   logic push_blk, pop_blk, ovf_q, ovf_d, unf_q, unf_d;

   // A push at SP_MIN or a pop at SP_MAX is suppressed and flagged instead.
   assign push_blk = RegSel[SP_IDX] && fs == FS_DEC && regs[SP_IDX] == SP_MIN;
   assign pop_blk  = RegSel[SP_IDX] && fs == FS_INC && regs[SP_IDX] == SP_MAX;
   assign sp_blk   = push_blk | pop_blk;
   assign ovf_d    = push_blk | (ovf_q & ~FlagClr);
   assign unf_d    = pop_blk  | (unf_q & ~FlagClr);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign SpOvf = ovf_q;
   assign SpUnf = unf_q;
`else
   logic unused_flag_clr;

   assign unused_flag_clr = FlagClr;
   assign sp_blk          = 1'b0;
   assign SpOvf           = 1'b0;
   assign SpUnf           = 1'b0;
`endif

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      arf_reg #(
         .DATA_W (DATA_W),
         .RST_VAL((i == SP_IDX) ? SP_MAX : {DATA_W{1'b0}})
      ) u_reg (
         .clk_i (Clock),
         .rst_ni(Reset_n),
         .en_i  (RegSel[i] & ~((i == SP_IDX) & sp_blk)),
         .fun_i (fs),
         .d_i   (I),
         .q_o   (regs[i])
      );
   end

   // Indices past the last register read as zero.
   for (genvar i = 0; i < 2**IDX_W; i++) begin : g_tab
      if (i < NUM_REGS) begin : g_hit
         assign tab[i] = regs[i];
      end else begin : g_miss
         assign tab[i] = '0;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign Out[k*DATA_W +: DATA_W] = tab[OutSel[k*IDX_W +: IDX_W]];
   end
endmodule

// File: doc/addr_reg_file_p.md
ADDR_REG_FILE_P -- requirements
Module: addr_reg_file_p

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, meaning the width of each register and data path.
REQ-002 The module SHALL have parameter NUM_REGS, default 4, meaning the number of address registers (minimum 2).
REQ-003 The module SHALL have parameter NUM_RD, default 2, meaning the number of independent read ports.
REQ-004 The module SHALL have parameter SP_IDX, default 3, meaning the register index that acts as stack pointer.
REQ-005 The module SHALL have parameters SP_MIN, default 0, and SP_MAX, default all-ones, meaning the stack pointer bounds (SP_MIN < SP_MAX).
REQ-006 The module SHALL have port Clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-007 The module SHALL have port Reset_n, input, 1 bit: the asynchronous, active-low reset.
REQ-008 The module SHALL have port I, input, DATA_W bits: the load data.
REQ-009 The module SHALL have port FunSel, input, 3 bits: the function code applied to the selected registers.
REQ-010 The module SHALL have port RegSel, input, NUM_REGS bits: an active-high one-bit-per-register enable mask.
REQ-011 The module SHALL have port OutSel, input, NUM_RD*IDX_W bits, where IDX_W = clog2(NUM_REGS): a packed read index per port.
REQ-012 The module SHALL have port Out, output, NUM_RD*DATA_W bits: the packed read data per port.
REQ-013 The module SHALL have port FlagClr, input, 1 bit: a synchronous clear of the sticky stack flags.
REQ-014 The module SHALL have ports SpOvf and SpUnf, output, 1 bit each: the sticky stack overflow and underflow flags.

Function
REQ-015 FunSel SHALL decode as follows: 000 DEC (minus 1), 001 INC (plus 1), 010 LOAD (I), 011 CLEAR (0), 100 LOAD_LO (low half = I low half, high half = 0), 101 LOAD_HI (high half = I low half, low half kept), 110/111 HOLD.
REQ-016 Every register whose RegSel bit is 1 SHALL apply the decoded function on the same rising edge; registers with RegSel bit 0 SHALL hold.
REQ-017 Non-SP registers SHALL wrap modulo 2^DATA_W: INC at all-ones gives 0, and DEC at 0 gives all-ones.
REQ-018 Read ports SHALL be combinational: Out slice k equals the register at index OutSel slice k, with zero added latency; a write becomes visible the cycle after the edge.
REQ-019 A read index of NUM_REGS or greater SHALL return 0.
REQ-020 Any number of read ports MAY address the same register simultaneously, and each SHALL return the identical value.
REQ-021 The stack grows downward: DEC on SP is a push, and INC on SP is a pop.
REQ-022 When SpOvf or SpUnf is set by a given edge, it SHALL be visible from the next cycle.
REQ-023 FlagClr=1 SHALL clear both flags on the edge; if a set condition occurs on the same edge, the set SHALL win.
REQ-024 LOAD, LOAD_LO, LOAD_HI and CLEAR on SP SHALL be applied unchecked, including values outside [SP_MIN, SP_MAX].

Reset
REQ-025 While Reset_n=0, all registers except SP SHALL be 0, SP SHALL be SP_MAX, and SpOvf and SpUnf SHALL be 0, independent of Clock.
REQ-026 The reset deassertion edge SHALL perform no update; the first functional update SHALL occur on the first rising Clock edge with Reset_n=1.
REQ-027 Reset asserted mid-operation SHALL abort any pending update with no partial write.

Configuration
REQ-028 The macro ARF_BOUNDS_CHECK_EN SHALL control stack bounds checking.
REQ-029 With ARF_BOUNDS_CHECK_EN defined, DEC on SP with SP==SP_MIN SHALL hold SP and set SpOvf.
REQ-030 With ARF_BOUNDS_CHECK_EN defined, INC on SP with SP==SP_MAX SHALL hold SP and set SpUnf.
REQ-031 Without ARF_BOUNDS_CHECK_EN, SP SHALL wrap like any other register, SpOvf and SpUnf SHALL be constant 0, and FlagClr SHALL be ignored.

Structure
REQ-032 A shared package arf_pkg SHALL hold the FunSel encodings (FS_DEC, FS_INC, FS_LOAD, FS_CLEAR, FS_LOAD_LO, FS_LOAD_HI) as named constants and the fun_sel_t typedef.
REQ-033 One sub-module, arf_reg, SHALL be instantiated NUM_REGS times via generate: a DATA_W register with async active-low reset, parametrised reset value, enable, and FunSel decode.
REQ-034 The SP bounds logic SHALL be implemented in the parent module, not in arf_reg.

Verification
REQ-035 Reset: assert Reset_n=0 mid-cycle -> all Out reads return 0 except index 3, which returns 16'hFFFF; SpOvf=SpUnf=0 immediately, without a clock edge.
REQ-036 Multi-select: RegSel=4'b0011, FunSel=LOAD, I=16'h1234, one edge -> reg0=reg1=16'h1234, reg2 and reg3 unchanged, Out visible next cycle.
REQ-037 Byte loads: reg2=16'hABCD; LOAD_HI with I=16'h0055 -> 16'h55CD; then LOAD_LO with I=16'h0077 -> 16'h0077.
REQ-038 Wrap: reg1=16'hFFFF, INC -> 16'h0000; DEC -> 16'hFFFF; OutSel index 3'b1xx with NUM_REGS=4 and IDX_W=2 is not applicable, so check an out-of-range index with NUM_REGS=3 returns 0.
REQ-039 With ARF_BOUNDS_CHECK_EN: SP=SP_MIN=16'h0100, DEC -> SP stays 16'h0100 and SpOvf=1; FlagClr plus another DEC on the same edge -> SpOvf remains 1; FlagClr alone -> SpOvf=0.
REQ-040 Without ARF_BOUNDS_CHECK_EN: SP=16'h0000, DEC -> 16'hFFFF, and the flags stay 0 throughout.
